// File: rtl/skewed_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : skewed_operand_fetch
//  Purpose  : Per-lane operand fetch for one systolic-array edge. Issues banked
//             SRAM reads, zero-fills masked lanes, and applies the optional
//             diagonal skew. Drains the skew pipeline after the last beat of a
//             tile, then pulses tile_done.
//  Revision : 1.0 - initial release
// ============================================================================
module skewed_operand_fetch #(
    parameter int LANES   = 8,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 18,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    skew_en,
    input  logic                    flush,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_last,
    input  logic [LANES*ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]        req_addr_valid,
    output logic [LANES-1:0]        mem_rd_en,
    output logic [LANES*ADDR_W-1:0] mem_rd_addr,
    input  logic [LANES*DATA_W-1:0] mem_rd_data,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_lane_valid,
    output logic                    busy,
    output logic                    tile_done,
    output logic [CNT_W-1:0]        beat_cnt
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;

    localparam int              DRN_W      = $clog2(MEM_LAT + LANES) + 1;
    localparam logic [DRN_W-1:0] c_DRN_SKEW = DRN_W'(MEM_LAT + LANES - 1);
    localparam logic [DRN_W-1:0] c_DRN_FLAT = DRN_W'(MEM_LAT);

    logic [1:0]              state_q, state_d;
    logic                    skew_q, skew_d;
    logic [DRN_W-1:0]        drn_q, drn_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LANES-1:0]        mask_q [MEM_LAT];
    logic [LANES-1:0]        mask_d [MEM_LAT];
    logic [MEM_LAT-1:0]      beat_q, beat_d;
    logic                    a_vld_q, a_vld_d;
    logic [LANES*DATA_W-1:0] a_data_q, a_data_d;

    logic                    w_accept;
    logic                    w_first;
    logic                    w_skew_eff;
    logic [LANES-1:0]        w_ret_mask;

    // flush outranks the handshake, so a beat offered alongside it is dropped
    assign w_accept   = req_valid && req_ready && !flush;
    assign w_first    = w_accept && (state_q == c_IDLE);
    assign w_skew_eff = (state_q == c_IDLE) ? skew_en : skew_q;
    assign w_ret_mask = mask_q[MEM_LAT-1];

    assign mem_rd_en   = w_accept ? req_addr_valid : '0;
    assign mem_rd_addr = req_addr;
    assign beat_cnt    = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = c_IDLE;
        end else begin
            case (state_q)
                c_IDLE:   if (w_accept) state_d = req_last ? c_DRAIN : c_STREAM;
                c_STREAM: if (w_accept && req_last) state_d = c_DRAIN;
                c_DRAIN:  if (drn_q == '0) state_d = c_IDLE;
                default:  state_d = c_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q != c_DRAIN);
        busy      = (state_q != c_IDLE);
        tile_done = (state_q == c_DRAIN) && (drn_q == '0) && !flush;
    end

    always_comb begin
        skew_d   = w_first ? skew_en : skew_q;
        drn_d    = drn_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        beat_d   = beat_q;
        a_vld_d  = 1'b0;
        a_data_d = '0;
        if (flush) begin
            drn_d  = '0;
            cnt_d  = '0;
            beat_d = '0;
            for (int s = 0; s < MEM_LAT; s++) mask_d[s] = '0;
        end else begin
            if (w_accept && req_last) begin
                drn_d = w_skew_eff ? c_DRN_SKEW : c_DRN_FLAT;
            end else if ((state_q == c_DRAIN) && (drn_q != '0)) begin
                drn_d = drn_q - DRN_W'(1);
            end
            if (w_first) begin
                cnt_d = CNT_W'(1);
            end else if (w_accept && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // lane mask and beat flag ride alongside the read for MEM_LAT cycles
            mask_d[0] = w_accept ? req_addr_valid : '0;
            beat_d[0] = w_accept;
            for (int s = 1; s < MEM_LAT; s++) begin
                mask_d[s] = mask_q[s-1];
                beat_d[s] = beat_q[s-1];
            end
            a_vld_d = beat_q[MEM_LAT-1];
            for (int i = 0; i < LANES; i++) begin
                a_data_d[i*DATA_W +: DATA_W] = w_ret_mask[i] ? mem_rd_data[i*DATA_W +: DATA_W] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_q   <= 1'b0;
            drn_q    <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            a_vld_q  <= 1'b0;
            a_data_q <= '0;
            for (int s = 0; s < MEM_LAT; s++) mask_q[s] <= '0;
        end else begin
            skew_q   <= skew_d;
            drn_q    <= drn_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            a_vld_q  <= a_vld_d;
            a_data_q <= a_data_d;
            mask_q   <= mask_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign out_lane_valid[0]   = a_vld_q;
            assign out_data[0 +: DATA_W] = a_data_q[0 +: DATA_W];
        end else begin : g_delay
            logic [DATA_W:0] dly_q [i];
            logic [DATA_W:0] dly_d [i];

            // feed zeros while unskewed so a later skewed tile never sees stale beats
            always_comb begin
                dly_d[0] = (skew_q && !flush) ? {a_vld_q, a_data_q[i*DATA_W +: DATA_W]} : '0;
                for (int k = 1; k < i; k++) begin
                    dly_d[k] = flush ? '0 : dly_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < i; k++) dly_q[k] <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign {out_lane_valid[i], out_data[i*DATA_W +: DATA_W]} =
                skew_q ? dly_q[i-1] : {a_vld_q, a_data_q[i*DATA_W +: DATA_W]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_skewed_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_skewed_operand_fetch
//  Purpose  : Self-checking bench for skewed_operand_fetch with a banked SRAM
//             model and per-lane expected-output queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_skewed_operand_fetch;

    localparam int LANES   = 8;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 18;
    localparam int MEM_LAT = 1;
    localparam int CNT_W   = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    skew_en;
    logic                    flush;
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_last;
    logic [LANES*ADDR_W-1:0] req_addr;
    logic [LANES-1:0]        req_addr_valid;
    logic [LANES-1:0]        mem_rd_en;
    logic [LANES*ADDR_W-1:0] mem_rd_addr;
    logic [LANES*DATA_W-1:0] mem_rd_data;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_lane_valid;
    logic                    busy;
    logic                    tile_done;
    logic [CNT_W-1:0]        beat_cnt;

    skewed_operand_fetch #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MEM_LAT(MEM_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .skew_en       (skew_en),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_last      (req_last),
        .req_addr      (req_addr),
        .req_addr_valid(req_addr_valid),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .out_data      (out_data),
        .out_lane_valid(out_lane_valid),
        .busy          (busy),
        .tile_done     (tile_done),
        .beat_cnt      (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        return a[7:0] + 8'h10 + a[15:8];
    endfunction

    // banked SRAM: garbage on idle banks exposes missing zero-fill
    logic [DATA_W-1:0] rd_pipe [MEM_LAT][LANES];
    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            rd_pipe[0][l] <= mem_rd_en[l] ? mem_val(mem_rd_addr[l*ADDR_W +: ADDR_W]) : 8'hEE;
            for (int s = 1; s < MEM_LAT; s++) rd_pipe[s][l] <= rd_pipe[s-1][l];
        end
    end
    always_comb begin
        mem_rd_data = '0;
        for (int l = 0; l < LANES; l++) mem_rd_data[l*DATA_W +: DATA_W] = rd_pipe[MEM_LAT-1][l];
    end

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } sb_t;
    sb_t lq [LANES][$];
    int  done_q [$];

    always @(negedge clk) begin : p_mon
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic              edone;
        if (rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                ev = 1'b0;
                ed = '0;
                if (lq[l].size() > 0 && lq[l][0].cyc == cyc) begin
                    ev = 1'b1;
                    ed = lq[l][0].data;
                    void'(lq[l].pop_front());
                end
                chk($sformatf("lane%0d_out", l), {55'd0, out_lane_valid[l], out_data[l*DATA_W +: DATA_W]},
                    {55'd0, ev, ed});
            end
            edone = 1'b0;
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                edone = 1'b1;
                void'(done_q.pop_front());
            end
            chk("tile_done", {63'd0, tile_done}, {63'd0, edone});
        end
    end

    logic in_tile   = 1'b0;
    logic tile_skew = 1'b0;
    int   last_acc  = 0;

    task automatic idle_cycle();
        req_valid = 1'b0;
        req_last  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic beat(input int base, input int b, input logic [LANES-1:0] mask,
                        input logic [LANES-1:0] exp_en, input logic last, input logic sk);
        logic [LANES*ADDR_W-1:0] a;
        int lat;
        for (int l = 0; l < LANES; l++) a[l*ADDR_W +: ADDR_W] = ADDR_W'(base + b*LANES + l);
        req_addr       = a;
        req_addr_valid = mask;
        req_valid      = 1'b1;
        req_last       = last;
        skew_en        = sk;
        if (!in_tile) begin
            tile_skew = sk;
            in_tile   = 1'b1;
        end
        #1;
        chk("req_ready_beat", {63'd0, req_ready}, 64'd1);
        chk("mem_rd_en", {56'd0, mem_rd_en}, {56'd0, exp_en});
        chk("mem_rd_addr7", {46'd0, mem_rd_addr[7*ADDR_W +: ADDR_W]}, {46'd0, a[7*ADDR_W +: ADDR_W]});
        for (int l = 0; l < LANES; l++) begin
            lat = MEM_LAT + 1 + (tile_skew ? l : 0);
            lq[l].push_back('{cyc: cyc + lat, data: mask[l] ? mem_val(a[l*ADDR_W +: ADDR_W]) : '0});
        end
        if (last) begin
            done_q.push_back(cyc + MEM_LAT + 1 + (tile_skew ? LANES - 1 : 0));
            in_tile  = 1'b0;
            last_acc = cyc;
        end
        @(posedge clk); #1;
        req_valid      = 1'b0;
        req_last       = 1'b0;
        req_addr_valid = '0;
    endtask

    task automatic trim(input int f);
        for (int l = 0; l < LANES; l++)
            while (lq[l].size() > 0 && lq[l][lq[l].size()-1].cyc > f) void'(lq[l].pop_back());
        while (done_q.size() > 0 && done_q[done_q.size()-1] >= f) void'(done_q.pop_back());
    endtask

    task automatic flush_cycle(input logic last);
        req_valid      = 1'b1;
        req_last       = last;
        req_addr_valid = '1;
        flush          = 1'b1;
        #1;
        chk("flush_rd_en", {56'd0, mem_rd_en}, 64'd0);
        trim(cyc);
        in_tile = 1'b0;
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_last  = 1'b0;
        chk("flush_valid", {56'd0, out_lane_valid}, 64'd0);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_cnt", {48'd0, beat_cnt}, 64'd0);
        chk("flush_ready", {63'd0, req_ready}, 64'd1);
    endtask

    typedef struct {
        int               nbeats;
        int               gap;
        logic             skew;
        logic             flip;
        logic [LANES-1:0] mask;
        int               base;
        logic [LANES-1:0] exp_rd_en;
        int               exp_cnt;
        int               exp_lat;
    } vec_t;
    vec_t vecs [7];

    task automatic run_tile(input vec_t v);
        logic found;
        for (int b = 0; b < v.nbeats; b++) begin
            if (b > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    chk("busy_gap", {63'd0, busy}, 64'd1);
                    idle_cycle();
                end
            end
            beat(v.base, b, v.mask, v.exp_rd_en, b == v.nbeats - 1, (v.flip && b >= 1) ? ~v.skew : v.skew);
        end
        chk("ready_drain", {63'd0, req_ready}, 64'd0);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (tile_done === 1'b1) found = 1'b1;
        end
        chk("done_seen", {63'd0, found}, 64'd1);
        chk("done_lat", 64'(cyc - last_acc), 64'(v.exp_lat));
        chk("beat_cnt", {48'd0, beat_cnt}, 64'(v.exp_cnt));
        @(posedge clk); #1;
        chk("ready_idle", {63'd0, req_ready}, 64'd1);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        chk("cnt_hold", {48'd0, beat_cnt}, 64'(v.exp_cnt));
    endtask

    initial begin
        vecs[0] = '{nbeats:1, gap:0, skew:1'b1, flip:1'b0, mask:8'hFF, base:0,
                    exp_rd_en:8'hFF, exp_cnt:1, exp_lat:9};
        vecs[1] = '{nbeats:1, gap:0, skew:1'b0, flip:1'b0, mask:8'hAA, base:'h40,
                    exp_rd_en:8'hAA, exp_cnt:1, exp_lat:2};
        vecs[2] = '{nbeats:4, gap:0, skew:1'b1, flip:1'b0, mask:8'hFF, base:'h100,
                    exp_rd_en:8'hFF, exp_cnt:4, exp_lat:9};
        vecs[3] = '{nbeats:3, gap:2, skew:1'b0, flip:1'b0, mask:8'h5C, base:'h2345,
                    exp_rd_en:8'h5C, exp_cnt:3, exp_lat:2};
        vecs[4] = '{nbeats:5, gap:0, skew:1'b1, flip:1'b1, mask:8'hF0, base:'h380,
                    exp_rd_en:8'hF0, exp_cnt:5, exp_lat:9};
        vecs[5] = '{nbeats:2, gap:1, skew:1'b0, flip:1'b1, mask:8'h81, base:'h1F0,
                    exp_rd_en:8'h81, exp_cnt:2, exp_lat:2};
        vecs[6] = '{nbeats:1, gap:0, skew:1'b1, flip:1'b0, mask:8'h00, base:'h20,
                    exp_rd_en:8'h00, exp_cnt:1, exp_lat:9};

        rst_n          = 1'b0;
        skew_en        = 1'b0;
        flush          = 1'b0;
        req_valid      = 1'b0;
        req_last       = 1'b0;
        req_addr       = '0;
        req_addr_valid = '0;
        #2;
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rd_en", {56'd0, mem_rd_en}, 64'd0);
        chk("rst_valid", {56'd0, out_lane_valid}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_done", {63'd0, tile_done}, 64'd0);
        chk("rst_cnt", {48'd0, beat_cnt}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) run_tile(vecs[t]);

        // flush three beats into a ten-beat skewed tile
        for (int b = 0; b < 3; b++) beat('h500, b, 8'hFF, 8'hFF, 1'b0, 1'b1);
        flush_cycle(1'b0);
        for (int k = 0; k < 10; k++) idle_cycle();
        run_tile(vecs[0]);

        // flush coincident with the last beat: no tile_done may follow
        beat('h600, 0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        flush_cycle(1'b1);
        for (int k = 0; k < 6; k++) idle_cycle();
        run_tile(vecs[1]);

        // asynchronous reset while draining a skewed tile
        beat('h700, 0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) idle_cycle();
        chk("drain_busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        for (int l = 0; l < LANES; l++) lq[l].delete();
        done_q.delete();
        #1;
        chk("arst_valid", {56'd0, out_lane_valid}, 64'd0);
        chk("arst_data", out_data, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_ready", {63'd0, req_ready}, 64'd1);
        chk("arst_done", {63'd0, tile_done}, 64'd0);
        chk("arst_cnt", {48'd0, beat_cnt}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
        for (int k = 0; k < 12; k++) idle_cycle();
        run_tile(vecs[2]);

        for (int k = 0; k < 4; k++) idle_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
